// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a length-prefixed big-endian byte stream into 32-bit
// words, writes them to instruction memory and holds the CPU until the program is in place.
module imem_loader #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [31:0] word_count
);

    typedef enum logic [2:0] {StIdle, StLen, StData, StWrite, StDone, StErr} state_e;

    state_e      state_q;
    logic [1:0]  bcnt_q;
    logic [23:0] shift_q;
    logic [31:0] len_q;
    logic        byte_ready_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic        cpu_hold_q;
    logic        done_q;
    logic        error_q;
    logic [31:0] word_count_q;

    logic        accept;
    logic [31:0] word_full;
    logic [31:0] count_inc;

    assign accept    = byte_valid && byte_ready_q;
    // Complete group as it will look once the current byte lands in bits[7:0].
    assign word_full = {shift_q, byte_in};
    assign count_inc = word_count_q + 32'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            bcnt_q       <= 2'd0;
            shift_q      <= 24'd0;
            len_q        <= 32'd0;
            byte_ready_q <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= BASE_ADDR;
            mem_wdata_q  <= 32'd0;
            cpu_hold_q   <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            word_count_q <= 32'd0;
        end else begin
            mem_we_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q      <= StLen;
                        byte_ready_q <= 1'b1;
                        bcnt_q       <= 2'd0;
                    end
                end
                StLen: begin
                    if (accept) begin
                        shift_q <= word_full[23:0];
                        bcnt_q  <= bcnt_q + 2'd1;
                        if (bcnt_q == 2'd3) begin
                            len_q <= word_full;
                            if (word_full == 32'd0) begin
                                state_q      <= StDone;
                                byte_ready_q <= 1'b0;
                                done_q       <= 1'b1;
                                cpu_hold_q   <= 1'b0;
                            end else if (word_full > DEPTH_WORDS) begin
                                state_q      <= StErr;
                                byte_ready_q <= 1'b0;
                                error_q      <= 1'b1;
                            end else begin
                                state_q <= StData;
                            end
                        end
                    end
                end
                StData: begin
                    if (accept) begin
                        shift_q <= word_full[23:0];
                        bcnt_q  <= bcnt_q + 2'd1;
                        if (bcnt_q == 2'd3) begin
                            state_q      <= StWrite;
                            byte_ready_q <= 1'b0;
                            mem_we_q     <= 1'b1;
                            mem_addr_q   <= BASE_ADDR + {word_count_q[29:0], 2'b00};
                            mem_wdata_q  <= word_full;
                        end
                    end
                end
                StWrite: begin
                    word_count_q <= count_inc;
                    if (count_inc == len_q) begin
                        state_q    <= StDone;
                        done_q     <= 1'b1;
                        cpu_hold_q <= 1'b0;
                    end else begin
                        state_q      <= StData;
                        byte_ready_q <= 1'b1;
                    end
                end
                StDone, StErr: begin
                    // Restart: a fresh session discards all status from the previous one.
                    if (start) begin
                        state_q      <= StLen;
                        byte_ready_q <= 1'b1;
                        bcnt_q       <= 2'd0;
                        done_q       <= 1'b0;
                        error_q      <= 1'b0;
                        cpu_hold_q   <= 1'b1;
                        word_count_q <= 32'd0;
                    end
                end
                default: begin
                    state_q      <= StIdle;
                    byte_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign byte_ready = byte_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign cpu_hold   = cpu_hold_q;
    assign done       = done_q;
    assign error      = error_q;
    assign word_count = word_count_q;

endmodule
